// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants for the ALU display path.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  localparam logic [3:0] SIGN_POS = 4'hF;
  localparam logic [3:0] SIGN_NEG = 4'hE;

  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_NONE = 4'b1111;

  localparam logic [15:0] VALUE_RST = 16'hF000;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_SCAN,
    ST_LOST
  } scan_state_t;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_seg_to_bcd.sv
// Segment pattern to nibble lookup.
// Sign position maps blank/minus to F/E; digits map to BCD.
module seg_to_bcd
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  input  logic       is_sign_pos,
  output logic [3:0] nibble,
  output logic       legal
);

  // pattern decode; illegal codes fall back to F (sign) or 0
  always_comb begin
    nibble = 4'd0;
    legal  = 1'b0;
    if (is_sign_pos) begin
      nibble = SIGN_POS;
      case (seg)
        SEG_BLANK: legal = 1'b1;
        SEG_MINUS: begin
          nibble = SIGN_NEG;
          legal  = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end else begin
      legal = 1'b1;
      case (seg)
        SEG_0: nibble = 4'd0;
        SEG_1: nibble = 4'd1;
        SEG_2: nibble = 4'd2;
        SEG_3: nibble = 4'd3;
        SEG_4: nibble = 4'd4;
        SEG_5: nibble = 4'd5;
        SEG_6: nibble = 4'd6;
        SEG_7: nibble = 4'd7;
        SEG_8: nibble = 4'd8;
        SEG_9: nibble = 4'd9;
        default: begin
          nibble = 4'd0;
          legal  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds the signed BCD word shown on a scanned 4-digit display.
// Settles each digit, assembles frames, accepts after repeated matches.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  anode,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        update,
  output logic        decode_err,
  output logic        scan_lost
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int MW = $clog2(STABLE_FRAMES + 1) + 1;

  localparam logic [SW-1:0] SETTLE_HIT =
    SW'(SETTLE_CYCLES - 2);
  localparam logic [SW-1:0] SETTLE_MAX =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_HIT =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_SAT =
    MW'(STABLE_FRAMES);

  scan_state_t state, state_nx;

  logic [3:0]    anode_q;
  logic          an_valid;
  logic [1:0]    an_idx;
  logic          an_change;
  logic          stable;
  logic          sample;
  logic          tmo_hit;
  logic          frame_done;
  logic          accept;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   frame_buf;
  logic [15:0]   prev_frame;
  logic [3:0]    seen;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nx;
  logic [3:0]    nib;
  logic          legal;

  // anode must have exactly one active-low bit to be a digit slot
  always_comb begin
    an_valid = 1'b0;
    an_idx   = 2'd0;
    case (anode)
      AN_THOU: begin
        an_valid = 1'b1;
        an_idx   = 2'd3;
      end
      AN_HUND: begin
        an_valid = 1'b1;
        an_idx   = 2'd2;
      end
      AN_TENS: begin
        an_valid = 1'b1;
        an_idx   = 2'd1;
      end
      AN_ONES: begin
        an_valid = 1'b1;
        an_idx   = 2'd0;
      end
      default: begin
        an_valid = 1'b0;
        an_idx   = 2'd0;
      end
    endcase
  end

  seg_to_bcd u_dec (
    .seg         (seg),
    .is_sign_pos (an_idx == 2'd3),
    .nibble      (nib),
    .legal       (legal)
  );

  assign an_change  = (anode != anode_q);
  assign stable     = an_valid && !an_change;
  assign sample     = stable && (settle_cnt == SETTLE_HIT);
  assign tmo_hit    = !an_change && (tmo_cnt == TMO_HIT);
  assign frame_done = (state == ST_SCAN) && (seen == 4'hF);

  // streak of identical frames, saturating at the acceptance depth
  always_comb begin
    match_nx = MW'(1);
    if (frame_buf == prev_frame) begin
      if (match_cnt >= MATCH_SAT)
        match_nx = MATCH_SAT;
      else
        match_nx = match_cnt + 1'b1;
    end
  end

  assign accept = frame_done &&
                  (match_nx == MATCH_SAT) &&
                  (frame_buf != value);

  // settle and activity-timeout counters
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_q    <= AN_NONE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      anode_q <= anode;
      if (!stable)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + 1'b1;
      if (an_change)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_HIT)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // scan state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_SYNC;
    else
      state <= state_nx;
  end

  // next state; an anode change beats a timeout
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_SYNC: begin
        if (tmo_hit)
          state_nx = ST_LOST;
        else if (anode == AN_THOU)
          state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (tmo_hit)
          state_nx = ST_LOST;
      end
      ST_LOST: begin
        if (an_change)
          state_nx = ST_SYNC;
      end
      default: state_nx = ST_SYNC;
    endcase
  end

  // frame assembly, frame matching and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_buf   <= '0;
      prev_frame  <= '0;
      seen        <= '0;
      match_cnt   <= '0;
      value       <= VALUE_RST;
      value_valid <= 1'b0;
      update      <= 1'b0;
      decode_err  <= 1'b0;
      scan_lost   <= 1'b0;
    end else begin
      update <= 1'b0;
      if ((state == ST_SCAN) && sample) begin
        frame_buf[{an_idx, 2'b00} +: 4] <= nib;
        seen[an_idx] <= 1'b1;
        if (!legal)
          decode_err <= 1'b1;
      end
      if (frame_done) begin
        prev_frame <= frame_buf;
        match_cnt  <= match_nx;
        seen       <= '0;
      end
      if (accept) begin
        value       <= frame_buf;
        update      <= 1'b1;
        value_valid <= 1'b1;
      end
      if ((state != ST_LOST) && tmo_hit) begin
        scan_lost <= 1'b1;
        seen      <= '0;
      end
      if ((state == ST_LOST) && an_change) begin
        scan_lost <= 1'b0;
        match_cnt <= '0;
        seen      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder.
// Drives scanned frames and compares against a frame-history model.
module tb_seven_seg_scan_decoder;

  localparam int ST = 16;
  localparam int SF = 3;
  localparam int TO = 512;
  localparam int DW = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [15:0] value;
  logic        value_valid;
  logic        update;
  logic        decode_err;
  logic        scan_lost;

  int n_chk  = 0;
  int n_fail = 0;
  int upd_cnt = 0;

  logic [6:0]  tab [10];
  logic [15:0] hist [$];
  logic [15:0] m_val;
  logic        m_valid;
  int          m_upd;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES  (ST),
    .STABLE_FRAMES  (SF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .anode       (anode),
    .value       (value),
    .value_valid (value_valid),
    .update      (update),
    .decode_err  (decode_err),
    .scan_lost   (scan_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && update) upd_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic dig(input logic [3:0] an,
                     input logic [6:0] sg,
                     input int ghost);
    for (int c = 0; c < DW; c++) begin
      @(negedge clk);
      anode = an;
      seg   = (c < ghost) ? 7'b1111001 : sg;
    end
  endtask

  task automatic frame(input logic [6:0] s3,
                       input logic [6:0] s2,
                       input logic [6:0] s1,
                       input logic [6:0] s0,
                       input int ghost);
    dig(4'b0111, s3, 0);
    dig(4'b1011, s2, 0);
    dig(4'b1101, s1, 0);
    dig(4'b1110, s0, ghost);
  endtask

  function automatic logic [15:0] word_of(input int n);
    int a;
    logic [3:0] s;
    a = (n < 0) ? -n : n;
    s = (n < 0) ? 4'hE : 4'hF;
    return {s, 4'(a / 100), 4'((a / 10) % 10),
            4'(a % 10)};
  endfunction

  // accept once the last SF frames since sync agree
  task automatic model_frame(input logic [15:0] w);
    bit same;
    hist.push_back(w);
    if (hist.size() >= SF) begin
      same = 1'b1;
      for (int i = 0; i < SF; i++)
        if (hist[hist.size() - 1 - i] != w) same = 1'b0;
      if (same && (w != m_val)) begin
        m_val   = w;
        m_valid = 1'b1;
        m_upd++;
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_val   = 16'hF000;
    m_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_value"}, value, m_val);
    chk({tag, "_valid"}, 16'(value_valid), 16'(m_valid));
    chk({tag, "_updates"}, 16'(upd_cnt), 16'(m_upd));
  endtask

  task automatic show_num(input int n, input int k,
                          input string tag);
    int a;
    logic [6:0] sg;
    a  = (n < 0) ? -n : n;
    sg = (n < 0) ? 7'b0111111 : 7'b1111111;
    for (int f = 0; f < k; f++) begin
      frame(sg, tab[a / 100], tab[(a / 10) % 10],
            tab[a % 10], 0);
      model_frame(word_of(n));
      chk_out(tag);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_value"}, value, 16'hF000);
    chk({tag, "_valid"}, 16'(value_valid), 16'd0);
    chk({tag, "_update"}, 16'(update), 16'd0);
    chk({tag, "_err"}, 16'(decode_err), 16'd0);
    chk({tag, "_lost"}, 16'(scan_lost), 16'd0);
  endtask

  initial begin
    int n;
    int k;
    int n2;
    int n3;
    bit got;
    tab[0] = 7'b1000000; tab[1] = 7'b1111001;
    tab[2] = 7'b0100100; tab[3] = 7'b0110000;
    tab[4] = 7'b0011001; tab[5] = 7'b0010010;
    tab[6] = 7'b0000010; tab[7] = 7'b1111000;
    tab[8] = 7'b0000000; tab[9] = 7'b0010000;
    m_upd = 0;
    model_reset();

    reset = 1'b1;
    anode = 4'b1111;
    seg   = 7'b1111111;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;

    show_num(579, 3, "pos579");
    show_num(-400, 3, "neg400");
    show_num(-400, 2, "neg400_hold");

    for (int f = 0; f < 3; f++) begin
      frame(7'b1111111, tab[3], tab[4], tab[6], 5);
      model_frame(16'hF346);
      chk_out("ghost");
    end
    chk("ghost_err", 16'(decode_err), 16'd0);

    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(1998, 0)) - 999;
      k = int'($urandom_range(4, 1));
      show_num(n, k, "rand");
    end
    chk("rand_err", 16'(decode_err), 16'd0);

    for (int f = 0; f < 3; f++) begin
      frame(7'b1111111, tab[3], 7'b1010101, tab[7], 0);
      model_frame(16'hF307);
      chk_out("illegal");
    end
    chk("illegal_err", 16'(decode_err), 16'd1);

    @(negedge clk);
    anode = 4'b1111;
    repeat (TO - 10) @(negedge clk);
    chk("lost_early", 16'(scan_lost), 16'd0);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (scan_lost) got = 1'b1;
    end
    chk("lost_set", 16'(got), 16'd1);
    chk_out("lost_hold");
    chk("lost_err", 16'(decode_err), 16'd1);
    hist.delete();

    anode = 4'b0111;
    seg   = 7'b1111111;
    @(negedge clk);
    @(negedge clk);
    chk("lost_clear", 16'(scan_lost), 16'd0);
    n2 = (m_val == word_of(-123)) ? 456 : -123;
    show_num(n2, 3, "resume");

    n3 = (n2 == 812) ? -55 : 812;
    show_num(n3, 2, "pre_rst");
    dig(4'b0111, 7'b1111111, 0);
    dig(4'b1011, tab[8], 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    reset = 1'b0;
    model_reset();
    show_num(n3, 3, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
